seq_bin2bcd: RTL and testbench

- Parametrised sequential binary-to-BCD converter using shift-and-add-3 (double dabble), one bit per clock.
- Converts the signed or unsigned multiplier product into packed BCD digits plus a sign flag for the display path.
- Uses a start/busy/done handshake and flags digit-count overflow.

---
 rtl/bcd_pkg.sv | 36 +++
 rtl/bcd_digit_adjust.sv | 14 +
 rtl/seq_bin2bcd.sv | 115 +++++++++++
 tb/tb_seq_bin2bcd.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

    // Converter FSM states.
    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    // A digit of 5 or more is pre-corrected by +3 so that the following
    // doubling carries into the next decimal digit.
    localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
    localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

    // Number of decimal digits needed to show 2^width - 1 (width up to 63).
    function automatic int min_digits(input int width);
        longint unsigned maxv;
        longint unsigned lim;
        int              d;
        if (width >= 63) begin
            maxv = 64'h7FFF_FFFF_FFFF_FFFF;
        end else begin
            maxv = (64'd1 << width) - 64'd1;
        end
        d   = 1;
        lim = 64'd10;
        for (int i = 0; i < 19; i++) begin
            if (maxv >= lim) begin
                d   = d + 1;
                lim = lim * 64'd10;
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// Double-dabble digit correction: adds 3 (mod 16) to a digit of 5 or more.
module bcd_digit_adjust
    import bcd_pkg::*;
(
    input  logic [3:0] digit_in,
    output logic [3:0] digit_out
);

    // Pre-correct the digit before the accumulator is doubled.
    always_comb begin
        digit_out = (digit_in >= BCD_ADJ_THRESH) ? (digit_in + BCD_ADJ_ADD) : digit_in;
    end

endmodule

// File: rtl/seq_bin2bcd.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one input bit per clock,
// with sign/magnitude handling and digit-count overflow detection.
//
// state | meaning
// IDLE  | waiting for start; result registers hold the last completed value
// CONV  | shifting magnitude bits into the BCD accumulator, cnt counts down
module seq_bin2bcd
    import bcd_pkg::*;
#(
    parameter int IN_W   = 16,
    parameter int DIGITS = 5,
    parameter int SIGNED = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [IN_W-1:0]       bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  sign_out,
    output logic                  ovf
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(IN_W + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(IN_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

    state_t             state;
    logic [IN_W-1:0]    shreg;
    logic [BCD_W-1:0]   acc;
    logic [BCD_W-1:0]   acc_adj;
    logic [BCD_W-1:0]   acc_next;
    logic [CNT_W-1:0]   cnt;
    logic               sign_r;
    logic               ovf_int;
    logic               carry_out;
    logic               neg_in;
    logic [IN_W-1:0]    mag;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adjust u_adj (
            .digit_in  (acc[4*g +: 4]),
            .digit_out (acc_adj[4*g +: 4])
        );
    end

    // Magnitude of the operand; the most negative value wraps to 2^(IN_W-1),
    // which is exactly its magnitude when read as unsigned.
    always_comb begin
        neg_in = (SIGNED != 0) && bin_in[IN_W-1];
        mag    = neg_in ? (~bin_in + IN_W'(1)) : bin_in;
    end

    // Next accumulator value: corrected digits doubled with the next magnitude bit.
    // The bit leaving the top digit means the value no longer fits.
    always_comb begin
        carry_out = acc_adj[BCD_W-1];
        acc_next  = {acc_adj[BCD_W-2:0], shreg[IN_W-1]};
    end

    // Control FSM, datapath registers and registered result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            shreg    <= '0;
            acc      <= '0;
            cnt      <= '0;
            sign_r   <= 1'b0;
            ovf_int  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            bcd_out  <= '0;
            sign_out <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        shreg   <= mag;
                        acc     <= '0;
                        sign_r  <= neg_in;
                        ovf_int <= 1'b0;
                        cnt     <= CNT_LOAD;
                        busy    <= 1'b1;
                        state   <= CONV;
                    end
                end
                CONV: begin
                    acc   <= acc_next;
                    shreg <= {shreg[IN_W-2:0], 1'b0};
                    cnt   <= cnt - CNT_W'(1);
                    if (carry_out) begin
                        ovf_int <= 1'b1;
                    end
                    // Terminal count: this edge performs the final shift.
                    if (cnt == CNT_LAST) begin
                        bcd_out  <= acc_next;
                        sign_out <= sign_r;
                        ovf      <= ovf_int | carry_out;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_bin2bcd.sv
// Self-checking bench for seq_bin2bcd: a signed 16-bit/5-digit instance and an
// unsigned 16-bit/4-digit instance, with expected results queued at stimulus time.
module tb_seq_bin2bcd;
    import bcd_pkg::*;

    typedef struct {
        logic [19:0] bcd;
        logic        sign;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        start_s = 1'b0;
    logic [15:0] bin_s = '0;
    logic        busy_s, done_s, sign_s, ovf_s;
    logic [19:0] bcd_s;

    logic        start_u = 1'b0;
    logic [15:0] bin_u = '0;
    logic        busy_u, done_u, sign_u, ovf_u;
    logic [15:0] bcd_u;

    int n_checks = 0;
    int n_fail   = 0;

    exp_t q_s[$];
    exp_t q_u[$];

    logic prev_done_s = 1'b0;

    seq_bin2bcd #(.IN_W(16), .DIGITS(5), .SIGNED(1)) dut_s (
        .clk(clk), .rst_n(rst_n), .start(start_s), .bin_in(bin_s),
        .busy(busy_s), .done(done_s), .bcd_out(bcd_s), .sign_out(sign_s), .ovf(ovf_s)
    );

    seq_bin2bcd #(.IN_W(16), .DIGITS(4), .SIGNED(0)) dut_u (
        .clk(clk), .rst_n(rst_n), .start(start_u), .bin_in(bin_u),
        .busy(busy_u), .done(done_u), .bcd_out(bcd_u), .sign_out(sign_u), .ovf(ovf_u)
    );

    always #5 clk = ~clk;

    // Reference: decimal digits of the magnitude, value mod 10^digits on overflow.
    function automatic exp_t model(input logic [15:0] v, input bit sgn, input int digits);
        exp_t        e;
        int unsigned mag;
        int unsigned lim;
        e.bcd  = '0;
        e.sign = sgn && v[15];
        if (e.sign) mag = 32'd65536 - {16'd0, v};
        else        mag = {16'd0, v};
        lim = 1;
        for (int i = 0; i < digits; i++) lim = lim * 10;
        e.ovf = (mag >= lim);
        for (int i = 0; i < digits; i++) begin
            e.bcd[4*i +: 4] = 4'(mag % 10);
            mag = mag / 10;
        end
        return e;
    endfunction

    // done must be a single-cycle pulse with busy low.
    always @(negedge clk) begin
        if (done_s) begin
            n_checks++;
            if (busy_s !== 1'b0 || prev_done_s) begin
                n_fail++;
                $display("FAIL done_pulse: busy=%b prev_done=%b required busy=0 prev_done=0", busy_s, prev_done_s);
            end
        end
        prev_done_s <= done_s;
    end

    task automatic convert_s(input logic [15:0] v);
        exp_t e;
        int   n;
        bit   seen;
        @(negedge clk);
        start_s = 1'b1;
        bin_s   = v;
        q_s.push_back(model(v, 1'b1, 5));
        @(negedge clk);
        start_s = 1'b0;
        bin_s   = 16'(~v);
        n = 1;
        seen = 1'b0;
        n_checks++;
        if (busy_s !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_start: got %b required 1 (v=%h)", busy_s, v);
        end
        while (n < 40 && !seen) begin
            @(negedge clk);
            n++;
            if (done_s) seen = 1'b1;
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL done_timeout: no done for v=%h", v);
            q_s.delete();
            return;
        end
        if (n !== 17) begin
            n_fail++;
            $display("FAIL latency: got %0d required 17 (v=%h)", n, v);
        end
        e = q_s.pop_front();
        n_checks++;
        if (bcd_s !== e.bcd || sign_s !== e.sign || ovf_s !== e.ovf) begin
            n_fail++;
            $display("FAIL result_s: v=%h got bcd=%h sign=%b ovf=%b required bcd=%h sign=%b ovf=%b",
                     v, bcd_s, sign_s, ovf_s, e.bcd, e.sign, e.ovf);
        end
    endtask

    task automatic convert_u(input logic [15:0] v);
        exp_t e;
        int   n;
        bit   seen;
        @(negedge clk);
        start_u = 1'b1;
        bin_u   = v;
        q_u.push_back(model(v, 1'b0, 4));
        @(negedge clk);
        start_u = 1'b0;
        n = 1;
        seen = 1'b0;
        while (n < 40 && !seen) begin
            @(negedge clk);
            n++;
            if (done_u) seen = 1'b1;
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL done_u_timeout: no done for v=%h", v);
            q_u.delete();
            return;
        end
        e = q_u.pop_front();
        n_checks++;
        if ({4'h0, bcd_u} !== e.bcd || sign_u !== e.sign || ovf_u !== e.ovf) begin
            n_fail++;
            $display("FAIL result_u: v=%h got bcd=%h sign=%b ovf=%b required bcd=%h sign=%b ovf=%b",
                     v, bcd_u, sign_u, ovf_u, e.bcd[15:0], e.sign, e.ovf);
        end
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if ({busy_s, done_s, bcd_s, sign_s, ovf_s} !== 24'h0 ||
            {busy_u, done_u, bcd_u, sign_u, ovf_u} !== 20'h0) begin
            n_fail++;
            $display("FAIL reset_state: s=%b%b_%h_%b%b u=%b%b_%h_%b%b required all zero",
                     busy_s, done_s, bcd_s, sign_s, ovf_s, busy_u, done_u, bcd_u, sign_u, ovf_u);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_signed_corners();
        convert_s(16'h0000);
        convert_s(16'h7FFF);
        convert_s(16'h8000);
        convert_s(16'hFFFF);
        convert_s(16'd9999);
        convert_s(16'hD8F1); // -9999
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   n, n1, n2;
        @(negedge clk);
        start_s = 1'b1;
        bin_s   = 16'd1234;
        q_s.push_back(model(16'd1234, 1'b1, 5));
        q_s.push_back(model(16'd9, 1'b1, 5));
        @(negedge clk);
        bin_s = 16'd9;
        n = 1; n1 = 0; n2 = 0;
        while (n < 80 && n2 == 0) begin
            @(negedge clk);
            n++;
            if (n1 != 0 && n == n1 + 1) start_s = 1'b0;
            if (done_s) begin
                if (n1 == 0) begin
                    n1 = n;
                    e = q_s.pop_front();
                    n_checks++;
                    if (bcd_s !== e.bcd || sign_s !== e.sign) begin
                        n_fail++;
                        $display("FAIL b2b_first: got %h/%b required %h/%b", bcd_s, sign_s, e.bcd, e.sign);
                    end
                end else begin
                    n2 = n;
                end
            end
        end
        start_s = 1'b0;
        n_checks++;
        if (n2 == 0 || n1 == 0) begin
            n_fail++;
            $display("FAIL b2b_timeout: first=%0d second=%0d", n1, n2);
            q_s.delete();
            return;
        end
        n_checks++;
        if (n2 - n1 !== 17) begin
            n_fail++;
            $display("FAIL b2b_spacing: got %0d required 17", n2 - n1);
        end
        e = q_s.pop_front();
        n_checks++;
        if (bcd_s !== e.bcd || sign_s !== e.sign) begin
            n_fail++;
            $display("FAIL b2b_second: got %h/%b required %h/%b", bcd_s, sign_s, e.bcd, e.sign);
        end
    endtask

    task automatic test_ignore_midconv();
        exp_t e;
        int   n;
        bit   seen;
        @(negedge clk);
        start_s = 1'b1;
        bin_s   = 16'd500;
        q_s.push_back(model(16'd500, 1'b1, 5));
        n = 0;
        seen = 1'b0;
        while (n < 40 && !seen) begin
            @(negedge clk);
            n++;
            if (n < 12) begin
                start_s = 1'($urandom_range(0, 1));
                bin_s   = 16'($urandom);
            end else begin
                start_s = 1'b0;
            end
            if (done_s) seen = 1'b1;
        end
        start_s = 1'b0;
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL midconv_timeout: no done");
            q_s.delete();
            return;
        end
        e = q_s.pop_front();
        n_checks++;
        if (bcd_s !== e.bcd || sign_s !== e.sign || ovf_s !== e.ovf) begin
            n_fail++;
            $display("FAIL midconv_result: got %h/%b/%b required %h/%b/%b",
                     bcd_s, sign_s, ovf_s, e.bcd, e.sign, e.ovf);
        end
    endtask

    task automatic test_unsigned_ovf();
        convert_u(16'd65535);
        convert_u(16'd9999);
        convert_u(16'd10000);
        convert_u(16'd0);
        convert_u(16'hFFFE);
    endtask

    task automatic test_reset_abort();
        bit saw_done;
        @(negedge clk);
        start_s = 1'b1;
        bin_s   = 16'd12345;
        @(negedge clk);
        start_s = 1'b0;
        repeat (7) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy_s, done_s, bcd_s, sign_s, ovf_s} !== 24'h0 ||
            {busy_u, done_u, bcd_u, sign_u, ovf_u} !== 20'h0) begin
            n_fail++;
            $display("FAIL reset_abort: s=%b%b_%h_%b%b u=%b%b_%h_%b%b required all zero",
                     busy_s, done_s, bcd_s, sign_s, ovf_s, busy_u, done_u, bcd_u, sign_u, ovf_u);
        end
        saw_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done_s) saw_done = 1'b1;
        end
        rst_n = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (done_s) saw_done = 1'b1;
        end
        n_checks++;
        if (saw_done) begin
            n_fail++;
            $display("FAIL reset_no_done: got done pulse required none");
        end
        convert_s(16'd42);
    endtask

    task automatic test_random_sweep();
        for (int i = 0; i < 1000; i++) begin
            convert_s(16'($urandom));
        end
    endtask

    initial begin
        $display("info: 16-bit unsigned needs %0d digits", min_digits(16));
        test_reset();
        test_signed_corners();
        test_back_to_back();
        test_ignore_midconv();
        test_unsigned_ovf();
        test_reset_abort();
        test_random_sweep();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
